// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key codes onto a 4x4 matrix keypad as timed press/release cycles
module keypad_emulator #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 1024
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [3:0]               i_key_code,
  input  logic                     i_key_valid,
  output logic                     o_key_ready,
  input  logic                     i_flush,
  input  logic [3:0]               i_col_n,
  output logic [3:0]               o_row_n,
  output logic                     o_pressed,
  output logic [3:0]               o_cur_key,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_pressed;
  logic [3:0]    r_cur_key;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [3:0]    w_head;
  logic [3:0]    w_rc;
  // {row, col} position of each code on the keypad matrix
  function automatic logic [3:0] f_rc(input logic [3:0] k);
    case (k)
      4'd1:    f_rc = {2'd0, 2'd0};
      4'd4:    f_rc = {2'd0, 2'd1};
      4'd7:    f_rc = {2'd0, 2'd2};
      4'd14:   f_rc = {2'd0, 2'd3};
      4'd2:    f_rc = {2'd1, 2'd0};
      4'd5:    f_rc = {2'd1, 2'd1};
      4'd8:    f_rc = {2'd1, 2'd2};
      4'd0:    f_rc = {2'd1, 2'd3};
      4'd3:    f_rc = {2'd2, 2'd0};
      4'd6:    f_rc = {2'd2, 2'd1};
      4'd9:    f_rc = {2'd2, 2'd2};
      4'd15:   f_rc = {2'd2, 2'd3};
      4'd10:   f_rc = {2'd3, 2'd0};
      4'd11:   f_rc = {2'd3, 2'd1};
      4'd12:   f_rc = {2'd3, 2'd2};
      default: f_rc = {2'd3, 2'd3};
    endcase
  endfunction
  assign o_key_ready  = r_count != CW'(DEPTH);
  assign w_push       = i_key_valid && o_key_ready && !i_flush;
  assign w_pop        = r_state == S_IDLE && r_count != '0 && !i_flush;
  assign w_head       = r_mem[r_rptr];
  assign w_rc         = f_rc(w_head);
  assign w_hit        = r_pressed && !i_col_n[r_col];
  assign o_row_n      = ~({3'b000, w_hit} << r_row);
  assign o_pressed    = r_pressed;
  assign o_cur_key    = r_cur_key;
  assign o_busy       = r_state != S_IDLE || r_count != '0;
  assign o_fifo_count = r_count;
  always_ff @(posedge i_clock)
    if (w_push) r_mem[r_wptr] <= i_key_code;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_pressed <= 1'b0;
      r_cur_key <= 4'd0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else if (i_flush) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_pressed <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      case (r_state)
        S_IDLE:
          if (w_pop) begin
            r_cur_key      <= w_head;
            {r_row, r_col} <= w_rc;
            r_timer        <= TW'(HOLD_CYCLES - 1);
            r_pressed      <= 1'b1;
            r_state        <= S_PRESS;
          end
        S_PRESS:
          if (r_timer == '0) begin
            r_pressed <= 1'b0;
            r_timer   <= TW'(GAP_CYCLES - 1);
            r_state   <= S_GAP;
          end else r_timer <= r_timer - TW'(1);
        S_GAP:
          if (r_timer == '0) r_state <= S_IDLE;
          else r_timer <= r_timer - TW'(1);
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
